// File: rtl/adder_display_pkg.sv
// Shared types and constants for the time-multiplexed adder/seven-segment scanner.
// Glyphs are active-low gfedcba, indexed by the hex value they draw.
package adder_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/digit_sum_decoder.sv
// Shared 4+4 adder feeding the hex glyph lookup; the carry lights the decimal point.
module digit_sum_decoder
    import adder_display_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [6:0] seg,
    output logic       dp
);

    logic [4:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign seg = GLYPH[sum[3:0]];
    assign dp  = ~sum[4];

endmodule

// File: rtl/adder_display_scheduler.sv
// Scans NUM_DIGITS operand pairs through one adder/decoder onto a common-anode display,
// with a blank gap between digits and a valid/ready port for updating operands.
module adder_display_scheduler
    import adder_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SHOW_CYC   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] load_idx,
    input  logic [3:0]                    load_a,
    input  logic [3:0]                    load_b,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;

    logic [3:0] a_reg [NUM_DIGITS];
    logic [3:0] b_reg [NUM_DIGITS];

    logic [31:0] load_idx_wide;
    logic        write_en;
    logic [6:0]  dec_seg;
    logic        dp_dec;

    // The digit currently being lit cannot be rewritten; out-of-range writes are dropped.
    assign load_ready    = !((state_reg == SHOW) && (load_idx == idx_reg));
    assign load_idx_wide = 32'(load_idx);
    assign write_en      = load_valid && load_ready && (load_idx_wide < 32'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                a_reg[i] <= 4'd0;
                b_reg[i] <= 4'd0;
            end
        end else if (write_en) begin
            a_reg[load_idx] <= load_a;
            b_reg[load_idx] <= load_b;
        end
    end

    digit_sum_decoder u_decoder (
        .a   (a_reg[idx_reg]),
        .b   (b_reg[idx_reg]),
        .seg (dec_seg),
        .dp  (dp_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            seg_reg   <= SEG_BLANK;
            dp_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        seg_next   = seg_reg;
        dp_next    = dp_reg;
        frame_done = 1'b0;

        unique case (state_reg)
            IDLE: begin
                idx_next = '0;
                cnt_next = '0;
                seg_next = SEG_BLANK;
                dp_next  = 1'b1;
                if (enable) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    seg_next   = SEG_BLANK;
                    dp_next    = 1'b1;
                end else if (cnt_reg == BLANK_LAST) begin
                    // Operands are sampled here, so a same-edge write lands only in storage.
                    seg_next   = dec_seg;
                    dp_next    = dp_dec;
                    cnt_next   = '0;
                    state_next = SHOW;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    seg_next   = SEG_BLANK;
                    dp_next    = 1'b1;
                end else if (cnt_reg == SHOW_LAST) begin
                    cnt_next   = '0;
                    state_next = BLANK;
                    frame_done = (idx_reg == IDX_LAST);
                    idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
        assign an[gi] = !((state_reg == SHOW) && (idx_reg == IDX_W'(gi)));
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule
